// File: rtl/top_cap_pkg.sv
// Shared types and helpers for the TOP response-capture stage: entry layout,
// MISR constants and the per-sample signature step.
package top_cap_pkg;

  localparam int          ENTRY_W   = 99;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  typedef struct packed {
    logic        f459_87_;
    logic        jjh;
    logic        wrr_898;
    logic [31:0] data_rd_T;
    logic [63:0] d877;
  } cap_entry_t;

  // One MISR shift: Galois feedback on the outgoing MSB, then fold in the
  // 99-bit sample compressed to 32 bits by XOR of its words and flags.
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input cap_entry_t  entry,
                                            input logic [31:0] poly);
    logic [31:0] fold;
    logic [31:0] fb;
    fold = entry.d877[63:32] ^ entry.d877[31:0] ^ entry.data_rd_T ^
           {29'd0, entry.f459_87_, entry.jjh, entry.wrr_898};
    fb   = sig[31] ? poly : 32'd0;
    return {sig[30:0], 1'b0} ^ fb ^ fold;
  endfunction

endpackage

// File: rtl/cap_fifo.sv
// Parameterised show-ahead synchronous FIFO; occupancy is tracked by a level
// counter so full/empty never depend on pointer equality.
module cap_fifo #(
  parameter int WIDTH = 99,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o
);

  localparam int             AW        = $clog2(DEPTH);
  localparam int             LW        = AW + 1;
  localparam logic [AW-1:0]  PTR_STEP  = AW'(1'b1);
  localparam logic [LW-1:0]  LVL_STEP  = LW'(1'b1);
  localparam logic [LW-1:0]  LVL_FULL  = LW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             valid_q, valid_d;
  logic             full_q, full_d;

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + PTR_STEP;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + PTR_STEP;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LVL_STEP;
      2'b01:   level_d = level_q - LVL_STEP;
      default: level_d = level_q;
    endcase
    valid_d = (level_d != '0);
    full_d  = (level_d == LVL_FULL);
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      valid_q  <= valid_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents beyond the level counter are never observed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = valid_q ? mem_q[rd_ptr_q] : '0;
  assign valid_o = valid_q;
  assign level_o = level_q;
  assign full_o  = full_q;

endmodule

// File: rtl/top_response_capture.sv
// Captures TOP result samples into a show-ahead FIFO for a slower reader and
// keeps a sticky overflow flag, a saturating sample count and a MISR signature.
module top_response_capture
  import top_cap_pkg::*;
#(
  parameter int          DEPTH = 8,
  parameter logic [31:0] SEED  = MISR_SEED,
  parameter logic [31:0] POLY  = MISR_POLY
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cap_en,
  input  logic [63:0]              d877,
  input  logic [31:0]              data_rd_T,
  input  logic                     wrr_898,
  input  logic                     jjh,
  input  logic                     f459_87_,
  input  logic                     clr_sig,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     overflow,
  output logic [15:0]              sample_cnt,
  output logic [31:0]              signature
);

  cap_entry_t  entry_s;
  logic        pop_s;
  logic        push_s;
  logic        drop_s;

  logic        overflow_q, overflow_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] sig_q, sig_d;

  assign entry_s = {f459_87_, jjh, wrr_898, data_rd_T, d877};
  assign pop_s   = rd_valid & rd_ready;
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push_s  = cap_en & (~full | pop_s);
  assign drop_s  = cap_en & full & ~pop_s;

  cap_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (entry_s),
    .rdata_o (rd_data),
    .valid_o (rd_valid),
    .level_o (level),
    .full_o  (full)
  );

  // Overflow, sample counter and signature next state; clr_sig beats push.
  always_comb begin
    overflow_d = overflow_q | drop_s;
    cnt_d      = cnt_q;
    sig_d      = sig_q;
    if (clr_sig) begin
      cnt_d = 16'd0;
      sig_d = SEED;
    end else if (push_s) begin
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
      sig_d = misr_step(sig_q, entry_s, POLY);
    end else begin
      cnt_d = cnt_q;
      sig_d = sig_q;
    end
  end

  // Status register bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      cnt_q      <= 16'd0;
      sig_q      <= SEED;
    end else begin
      overflow_q <= overflow_d;
      cnt_q      <= cnt_d;
      sig_q      <= sig_d;
    end
  end

  assign overflow   = overflow_q;
  assign sample_cnt = cnt_q;
  assign signature  = sig_q;

endmodule

// File: tb/tb_top_response_capture.sv
// Self-checking bench for top_response_capture: directed plan steps followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_top_response_capture;

  localparam logic [31:0] SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset, cap_en, wrr_898, jjh, f459_87_, clr_sig, rd_ready;
  logic [63:0] d877;
  logic [31:0] data_rd_T;
  logic        rd_valid, full, overflow;
  logic [98:0] rd_data;
  logic [3:0]  level;
  logic [15:0] sample_cnt;
  logic [31:0] signature;

  int total = 0;
  int bad   = 0;

  logic [98:0] mq[$];
  logic        m_ovf;
  int          m_cnt;
  logic [31:0] m_sig;

  top_response_capture #(.DEPTH(DEPTH), .SEED(SEED), .POLY(POLY)) dut (
    .clk(clk), .reset(reset), .cap_en(cap_en), .d877(d877), .data_rd_T(data_rd_T),
    .wrr_898(wrr_898), .jjh(jjh), .f459_87_(f459_87_), .clr_sig(clr_sig),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
    .full(full), .overflow(overflow), .sample_cnt(sample_cnt), .signature(signature)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_sig(input logic [31:0] s, input logic [98:0] e);
    logic [31:0] fold;
    logic [31:0] shifted;
    fold    = e[63:32] ^ e[31:0] ^ e[95:64] ^ {29'd0, e[98:96]};
    shifted = s << 1;
    if (s[31]) shifted = shifted ^ POLY;
    return shifted ^ fold;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [98:0] head;
    head = (mq.size() > 0) ? mq[0] : 99'd0;
    check("level",      128'(level),      128'(mq.size()));
    check("rd_valid",   128'(rd_valid),   128'(mq.size() > 0));
    check("full",       128'(full),       128'(mq.size() == DEPTH));
    check("overflow",   128'(overflow),   128'(m_ovf));
    check("sample_cnt", 128'(sample_cnt), 128'(m_cnt));
    check("signature",  128'(signature),  128'(m_sig));
    check("rd_data",    128'(rd_data),    128'(head));
  endtask

  task automatic drive(input logic ce, input logic [63:0] d, input logic [31:0] rdt,
                       input logic [2:0] flags, input logic rr, input logic clr, input logic rst);
    cap_en = ce; d877 = d; data_rd_T = rdt; {f459_87_, jjh, wrr_898} = flags;
    rd_ready = rr; clr_sig = clr; reset = rst;
  endtask

  // Advance the model by one cycle from its own state, clock the DUT, compare.
  task automatic tick();
    logic [98:0] e;
    bit vld, ful, pop, push;
    e    = {f459_87_, jjh, wrr_898, data_rd_T, d877};
    vld  = mq.size() > 0;
    ful  = mq.size() == DEPTH;
    pop  = vld && rd_ready;
    push = cap_en && (!ful || pop);
    if (reset) begin
      mq.delete(); m_ovf = 1'b0; m_cnt = 0; m_sig = SEED;
    end else begin
      if (cap_en && ful && !pop) m_ovf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
      if (clr_sig) begin
        m_sig = SEED; m_cnt = 0;
      end else if (push) begin
        m_sig = ref_sig(m_sig, e);
        if (m_cnt < 65535) m_cnt++;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    mq.delete(); m_ovf = 1'b0; m_cnt = 0; m_sig = SEED;
    drive(1'b0, 64'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    check("rst_sig_const", 128'(signature), 128'(32'hFFFF_FFFF));

    // Single zero sample from SEED.
    drive(1'b1, 64'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("zero_push_sig", 128'(signature), 128'(32'hFB3E_E249));
    check("zero_push_cnt", 128'(sample_cnt), 128'(16'd1));

    // Halves of d877 cancel in the fold.
    drive(1'b0, 64'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 64'h0000_0001_0000_0001, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0); tick();
    check("cancel_sig", 128'(signature), 128'(32'hFB3E_E249));

    // Fill to full, overflow on the ninth, then drain in order.
    drive(1'b0, 64'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'd0, 32'(i), 3'd0, 1'b0, 1'b0, 1'b0); tick();
    end
    check("fill_full", 128'(full), 128'(1'b1));
    drive(1'b1, 64'd0, 32'd9, 3'd0, 1'b0, 1'b0, 1'b0); tick();
    check("ovf_set", 128'(overflow), 128'(1'b1));
    check("ovf_cnt", 128'(sample_cnt), 128'(16'd8));
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", 128'(rd_data[95:64]), 128'(i));
      drive(1'b0, 64'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0); tick();
    end
    check("drain_empty", 128'(rd_valid), 128'(1'b0));

    // Full FIFO with simultaneous push and pop across pointer wrap.
    drive(1'b0, 64'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1); tick();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 64'd0, 32'(i), 3'd0, 1'b0, 1'b0, 1'b0); tick();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, {$urandom, $urandom}, 32'(100 + i), 3'($urandom), 1'b1, 1'b0, 1'b0); tick();
    end
    check("pp_level", 128'(level), 128'(4'd8));
    check("pp_cnt", 128'(sample_cnt), 128'(16'd28));
    check("pp_noovf", 128'(overflow), 128'(1'b0));

    // Clear beats same-cycle push, entry still stored.
    drive(1'b0, 64'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b1, 64'd0, 32'hDEAD_BEEF, 3'd0, 1'b0, 1'b1, 1'b0); tick();
    check("clr_sig", 128'(signature), 128'(32'hFFFF_FFFF));
    check("clr_cnt", 128'(sample_cnt), 128'(16'd0));
    check("clr_data", 128'(rd_data[95:64]), 128'(32'hDEAD_BEEF));

    // Reset with five entries pending.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {$urandom, $urandom}, $urandom, 3'($urandom), 1'b0, 1'b0, 1'b0); tick();
    end
    check("pre_rst_level", 128'(level), 128'(4'd5));
    drive(1'b1, 64'd0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b1); tick();
    check("rst_level", 128'(level), 128'(4'd0));

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) < 60), {$urandom, $urandom}, $urandom, 3'($urandom),
            ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 4),
            ($urandom_range(0, 199) == 0));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/top_response_capture.md
Name: top_response_capture

Overview:
- Downstream stage of TOP: samples TOP's result outputs (d877, data_rd_T, wrr_898, jjh, f459_87_) into a small show-ahead FIFO.
- Lets a slower reader drain captured results over a valid/ready handshake.
- Keeps a 32-bit MISR signature over every accepted sample, for one-word pass/fail comparison of a whole run.
- Sits between TOP and the result checker / bench scoreboard.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- SEED, 32'hFFFF_FFFF, MISR value after reset or clear.
- POLY, 32'h04C1_1DB7, MISR feedback polynomial.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- cap_en  in  1  capture request this cycle.
- d877  in  64  TOP result word.
- data_rd_T  in  32  TOP read-data word.
- wrr_898  in  1  TOP flag.
- jjh  in  1  TOP flag.
- f459_87_  in  1  TOP flag.
- clr_sig  in  1  synchronous clear of signature and sample counter.
- rd_ready  in  1  reader accepts head entry.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  99  head entry = {f459_87_, jjh, wrr_898, data_rd_T, d877}.
- level  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  level == DEPTH.
- overflow  out  1  sticky: a sample was dropped.
- sample_cnt  out  16  accepted samples; saturates at 16'hFFFF.
- signature  out  32  MISR value.

Behaviour:
- Reset values: level=0, rd_valid=0, full=0, overflow=0, sample_cnt=0, signature=SEED. rd_data is don't-care while empty; the implementation drives 0.
- Reset mid-operation empties the FIFO at once and discards all pending entries.
- Reset has priority over everything.
- pop = rd_valid & rd_ready.
- push = cap_en & (~full | pop). A write into a full FIFO is accepted when a pop occurs in the same cycle.
- Drop = cap_en & full & ~pop. A drop sets overflow on the next edge; overflow clears only on reset.
- Dropped samples do not touch sample_cnt or signature.
- Write latency: a sample pushed at edge N appears on rd_data/rd_valid after edge N if the FIFO was empty. Show-ahead: no read latency.
- Simultaneous push and pop with level=0 is impossible, because pop requires rd_valid.
- Simultaneous push and pop otherwise: level is unchanged and the pointers both advance.
- Pointers wrap modulo DEPTH. full and empty are derived from the level counter, not from pointer equality.
- rd_data stays stable while rd_valid=1 and rd_ready=0.
- Signature step on each push:
  - fold = d877[63:32] ^ d877[31:0] ^ data_rd_T ^ {29'b0, f459_87_, jjh, wrr_898}.
  - sig' = {sig[30:0],1'b0} ^ (sig[31] ? POLY : 0) ^ fold.
- sample_cnt increments on push and holds at FFFF.
- clr_sig sets signature=SEED and sample_cnt=0. It wins over a same-cycle push: the entry is still stored in the FIFO but not folded or counted.
- clr_sig does not affect FIFO contents or overflow.

Decomposition:
- Shared package top_cap_pkg holds:
  - typedef cap_entry_t, a packed struct {f459_87_, jjh, wrr_898, data_rd_T, d877};
  - constants ENTRY_W=99, MISR_SEED, MISR_POLY;
  - function misr_step(sig, entry).
- One sub-module, cap_fifo: a parameterised show-ahead synchronous FIFO (push/pop/level/full). The top adds capture gating, overflow, counter and MISR.

Test Plan:
- Reset, then one push with d877=0, data_rd_T=0, flags=0 -> signature=32'hFB3E_E249, sample_cnt=1, level=1, rd_valid=1.
- One push with d877=64'h0000_0001_0000_0001, data_rd_T=0, flags=0 from SEED (fold=0) -> signature=32'hFB3E_E249.
- 8 pushes of data_rd_T=1..8 with rd_ready=0 -> full=1, level=8. 9th cap_en -> overflow=1, level=8, sample_cnt=8. Then drain: rd_data.data_rd_T reads 1..8 in order, rd_valid=0 after the 8th pop.
- Full FIFO with cap_en=1 and rd_ready=1 for 20 cycles -> no overflow, level stays 8, sample_cnt=28, order preserved across pointer wrap.
- clr_sig=1 with a same-cycle push of data_rd_T=32'hDEAD_BEEF -> signature=SEED, sample_cnt=0, entry readable on rd_data.
- reset asserted with level=5 -> next cycle level=0, rd_valid=0, overflow=0, signature=SEED.
